pwm_bank: RTL and testbench

Parametrised multi-channel PWM generator sharing one counter across all channels, driving LEDs or other slow outputs from the top level. It generalises the fixed per-output PWM instances with:
- run-time writable per-channel compare values, double-buffered so they update only at a period boundary;
- a clock prescaler;
- a selectable edge-aligned or center-aligned mode;
- a period-start strobe.

---
 rtl/pwm_bank.sv | 78 +++++++
 tb/tb_pwm_bank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with shared counter, prescaler, double-buffered compares, edge/center modes
//   clk, rst          : clock, synchronous active-high reset
//   enable            : run counter and outputs; low forces a fresh start state
//   center            : 0 edge-aligned, 1 center-aligned (latched at period boundary)
//   prescale          : counter advances every prescale+1 cycles
//   wr_en/addr/data   : write a shadow compare register
//   pwm               : registered PWM outputs
//   period_start      : registered one-cycle pulse when a new period begins
module pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int CTR_LEN = 8,
  parameter int PRESC_LEN = 4,
  localparam int ADDR_LEN = $clog2(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 center,
  input  logic [PRESC_LEN-1:0] prescale,
  input  logic                 wr_en,
  input  logic [ADDR_LEN-1:0]  wr_addr,
  input  logic [CTR_LEN-1:0]   wr_data,
  output logic [CHANNELS-1:0]  pwm,
  output logic                 period_start
);
  localparam logic [CTR_LEN-1:0] MAX = '1;
  localparam logic [CTR_LEN-1:0] ONE = CTR_LEN'(1);
  logic [PRESC_LEN-1:0] presc_cnt;
  logic [CTR_LEN-1:0] ctr, ctr_nxt;
  logic dir, dir_nxt, mode, tick, boundary;
  logic [CTR_LEN-1:0] shadow [CHANNELS];
  logic [CTR_LEN-1:0] active [CHANNELS];
  // boundary is the tick that reloads ctr with 0
  always_comb begin
    tick = enable && presc_cnt == prescale;
    boundary = tick && (mode ? dir && ctr == ONE : ctr == MAX);
    ctr_nxt = (mode && (dir || ctr == MAX)) ? ctr - 1'b1 : ctr + 1'b1;
    dir_nxt = mode && (dir ? ctr != ONE : ctr == MAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      ctr <= '0;
      dir <= 1'b0;
      mode <= 1'b0;
      pwm <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (!enable) begin
        presc_cnt <= '0;
        ctr <= '0;
        dir <= 1'b0;
        pwm <= '0;
        period_start <= 1'b0;
        mode <= center;
        for (int i = 0; i < CHANNELS; i++) active[i] <= shadow[i];
      end else begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        if (tick) begin
          ctr <= ctr_nxt;
          dir <= dir_nxt;
        end
        period_start <= boundary;
        for (int i = 0; i < CHANNELS; i++) pwm[i] <= ctr < active[i];
        if (boundary) begin
          mode <= center;
          for (int i = 0; i < CHANNELS; i++) active[i] <= shadow[i];
        end
      end
      // active above samples the pre-write shadow when a write lands on a boundary
      if (wr_en && int'(wr_addr) < CHANNELS) shadow[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: random and directed checks of pwm_bank against a period-phase reference model
module tb_pwm_bank;
  localparam int CH = 6, CL = 3, PL = 4, AL = $clog2(CH), MAX = (1 << CL) - 1;
  logic clk = 1'b0, rst, enable, center, wr_en, period_start;
  logic [PL-1:0] prescale;
  logic [AL-1:0] wr_addr;
  logic [CL-1:0] wr_data;
  logic [CH-1:0] pwm;
  int n_checks = 0, n_fail = 0;
  bit armed = 1'b0;
  int m_presc, m_phase, m_sh[CH], m_ac[CH];
  bit m_mode;
  logic [CH-1:0] m_pwm;
  logic m_ps;
  int cnt[CH];
  int ps_cnt;
  always #5 clk = ~clk;
  pwm_bank #(.CHANNELS(CH), .CTR_LEN(CL), .PRESC_LEN(PL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .center(center), .prescale(prescale),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pwm(pwm), .period_start(period_start)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask
  // Model tracks the tick index within the period; ctr is derived from it
  task automatic model_step();
    int per, c;
    bit tick, bnd;
    if (rst) begin
      m_presc = 0; m_phase = 0; m_mode = 0; m_pwm = '0; m_ps = 0;
      for (int i = 0; i < CH; i++) begin m_sh[i] = 0; m_ac[i] = 0; end
      return;
    end
    if (!enable) begin
      m_presc = 0; m_phase = 0; m_pwm = '0; m_ps = 0; m_mode = center;
      for (int i = 0; i < CH; i++) m_ac[i] = m_sh[i];
    end else begin
      per = m_mode ? 2 * MAX : MAX + 1;
      c = (m_mode && m_phase > MAX) ? 2 * MAX - m_phase : m_phase;
      tick = m_presc == int'(prescale);
      bnd = tick && m_phase == per - 1;
      for (int i = 0; i < CH; i++) m_pwm[i] = c < m_ac[i];
      m_ps = bnd;
      m_presc = tick ? 0 : (m_presc + 1) % (1 << PL);
      if (tick) m_phase = bnd ? 0 : m_phase + 1;
      if (bnd) begin
        m_mode = center;
        for (int i = 0; i < CH; i++) m_ac[i] = m_sh[i];
      end
    end
    if (wr_en && int'(wr_addr) < CH) m_sh[wr_addr] = int'(wr_data);
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("pwm", 32'(pwm), 32'(m_pwm));
      chk("period_start", 32'(period_start), 32'(m_ps));
    end
  end
  task automatic wr(int a, int d);
    wr_en = 1'b1; wr_addr = AL'(a); wr_data = CL'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic win(int n);
    ps_cnt = 0;
    for (int i = 0; i < CH; i++) cnt[i] = 0;
    repeat (n) begin
      @(negedge clk);
      ps_cnt += int'(period_start);
      for (int i = 0; i < CH; i++) cnt[i] += int'(pwm[i]);
    end
  endtask
  task automatic wait_ps();
    int k = 0;
    do begin @(negedge clk); k++; end while (period_start !== 1'b1 && k < 100);
    chk("period_start_timeout", 32'(period_start), 32'(1));
  endtask
  task automatic restart(int p, bit c);
    enable = 1'b0; prescale = PL'(p); center = c;
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; enable = 1'b0; center = 1'b0; prescale = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_pwm", 32'(pwm), 0);
    chk("reset_ps", 32'(period_start), 0);
    armed = 1'b1; rst = 1'b0;
    for (int i = 0; i < CH; i++) wr(i, i);
    restart(0, 1'b0);
    win(8);
    for (int i = 0; i < CH; i++) chk($sformatf("edge_duty_ch%0d", i), 32'(cnt[i]), 32'(i));
    chk("edge_ps_per_period", 32'(ps_cnt), 1);
    repeat (3) @(negedge clk);
    wr(3, 6);
    wait_ps();
    win(8);
    chk("dbuf_ch3_new", 32'(cnt[3]), 6);
    wait_ps();
    repeat (7) @(negedge clk);
    wr(5, 1);
    chk("boundary_ps", 32'(period_start), 1);
    win(8);
    chk("bwrite_ch5_old", 32'(cnt[5]), 5);
    win(8);
    chk("bwrite_ch5_new", 32'(cnt[5]), 1);
    restart(2, 1'b0);
    win(24);
    chk("presc_ch4", 32'(cnt[4]), 12);
    chk("presc_ch1", 32'(cnt[1]), 3);
    chk("presc_ps", 32'(ps_cnt), 1);
    enable = 1'b0;
    wr(2, 4);
    restart(0, 1'b1);
    win(14);
    chk("center_ch2", 32'(cnt[2]), 7);
    chk("center_ch1", 32'(cnt[1]), 1);
    chk("center_ch3", 32'(cnt[3]), 11);
    chk("center_ps", 32'(ps_cnt), 1);
    center = 1'b0;
    wait_ps();
    win(8);
    chk("center_off_ch2", 32'(cnt[2]), 4);
    chk("center_off_ps", 32'(ps_cnt), 1);
    enable = 1'b0;
    wr(6, 7);
    wr(7, 7);
    restart(0, 1'b0);
    win(8);
    chk("addr_ch0", 32'(cnt[0]), 0);
    chk("addr_ch1", 32'(cnt[1]), 1);
    chk("addr_ch2", 32'(cnt[2]), 4);
    chk("addr_ch3", 32'(cnt[3]), 6);
    chk("addr_ch4", 32'(cnt[4]), 4);
    chk("addr_ch5", 32'(cnt[5]), 1);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_pwm", 32'(pwm), 0);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_ps", 32'(period_start), 0);
    win(16);
    for (int i = 0; i < CH; i++) chk($sformatf("rst_shadow_ch%0d", i), 32'(cnt[i]), 0);
    repeat (3000) begin
      wr_en = ($urandom % 4) == 0;
      wr_addr = AL'($urandom);
      wr_data = CL'($urandom);
      if ($urandom % 60 == 0) center = ~center;
      if ($urandom % 80 == 0) prescale = PL'($urandom % 4);
      if (enable ? $urandom % 150 == 0 : $urandom % 5 == 0) enable = ~enable;
      rst = ($urandom % 500) == 0;
      @(negedge clk);
    end
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
